// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory read-port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W        = 16;
    localparam int unsigned NDEM_DEF      = 2;
    localparam int unsigned NPF_DEF       = 2;
    localparam int unsigned MAX_OUT_DEF   = 8;
    localparam int unsigned PF_MAX_DEF    = 4;
    localparam int unsigned AGE_LIMIT_DEF = 16;

    typedef struct packed {
        logic              valid;
        logic              is_pf;
        logic [ADDR_W-1:0] addr;
    } inflight_entry_t;

endpackage

// File: rtl/mem_inflight_table.sv
// In-flight read table: CAM lookup for every requester, allocate/promote for
// the arbitration winner, free on matching memory responses.
module mem_inflight_table
    import mem_arb_pkg::*;
#(
    parameter int unsigned NQ      = 4,
    parameter int unsigned MAX_OUT = MAX_OUT_DEF,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NQ*ADDR_W-1:0] q_addr,
    output logic [NQ-1:0]        q_hit,
    input  logic                 acc_valid,
    input  logic                 acc_pf,
    input  logic [ADDR_W-1:0]    acc_addr,
    input  logic                 rsp_valid,
    input  logic [ADDR_W-1:0]    rsp_addr,
    output logic [CNT_W-1:0]     outstanding,
    output logic [CNT_W-1:0]     pf_count
);

    localparam int unsigned IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    inflight_entry_t        entries_q [MAX_OUT];
    inflight_entry_t        entries_d [MAX_OUT];
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       pf_d;
    logic                   acc_hit;
    logic [IDX_W-1:0]       hit_idx;
    logic                   free_found;
    logic [IDX_W-1:0]       free_idx;

    // Per-requester match against pre-edge table contents
    always_comb begin
        q_hit = '0;
        for (int q = 0; q < NQ; q++) begin
            for (int e = 0; e < MAX_OUT; e++) begin
                if (entries_q[e].valid && entries_q[e].addr == q_addr[q*ADDR_W +: ADDR_W]) begin
                    q_hit[q] = 1'b1;
                end
            end
        end
    end

    // Next table state; counts are recomputed from the next contents so a
    // same-cycle promote and free of one entry cannot double-decrement.
    always_comb begin
        entries_d  = entries_q;
        acc_hit    = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        cnt_d      = '0;
        pf_d       = '0;
        for (int e = 0; e < MAX_OUT; e++) begin
            if (entries_q[e].valid && entries_q[e].addr == acc_addr) begin
                acc_hit = 1'b1;
                hit_idx = IDX_W'(e);
            end
            if (!free_found && !entries_q[e].valid) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(e);
            end
        end
        if (acc_valid) begin
            if (acc_hit) begin
                if (!acc_pf) begin
                    entries_d[hit_idx].is_pf = 1'b0;
                end
            end else if (free_found) begin
                entries_d[free_idx].valid = 1'b1;
                entries_d[free_idx].is_pf = acc_pf;
                entries_d[free_idx].addr  = acc_addr;
            end
        end
        if (rsp_valid) begin
            for (int e = 0; e < MAX_OUT; e++) begin
                if (entries_q[e].valid && entries_q[e].addr == rsp_addr) begin
                    entries_d[e].valid = 1'b0;
                    entries_d[e].is_pf = 1'b0;
                end
            end
        end
        for (int e = 0; e < MAX_OUT; e++) begin
            cnt_d = cnt_d + CNT_W'(entries_d[e].valid);
            pf_d  = pf_d + CNT_W'(entries_d[e].valid & entries_d[e].is_pf);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < MAX_OUT; e++) begin
                entries_q[e] <= '0;
            end
            outstanding <= '0;
            pf_count    <= '0;
        end else begin
            for (int e = 0; e < MAX_OUT; e++) begin
                entries_q[e] <= entries_d[e];
            end
            outstanding <= cnt_d;
            pf_count    <= pf_d;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Memory read-port arbiter: demand-over-prefetch selection with an age escape,
// in-flight merge, prefetch throttling and a one-cycle issue register.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int unsigned NDEM      = NDEM_DEF,
    parameter int unsigned NPF       = NPF_DEF,
    parameter int unsigned MAX_OUT   = MAX_OUT_DEF,
    parameter int unsigned PF_MAX    = PF_MAX_DEF,
    parameter int unsigned AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NDEM-1:0]        dem_valid,
    input  logic [ADDR_W*NDEM-1:0] dem_addr,
    output logic [NDEM-1:0]        dem_grant,
    input  logic [NPF-1:0]         pf_valid,
    input  logic [ADDR_W*NPF-1:0]  pf_addr,
    output logic [NPF-1:0]         pf_grant,
    output logic                   mem_re,
    output logic [ADDR_W-1:0]      mem_raddr,
    input  logic                   mem_ready,
    input  logic [ADDR_W-1:0]      mem_addr_out,
    output logic [3:0]             outstanding,
    output logic                   busy
);

    localparam int unsigned NQ     = NDEM + NPF;
    localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
    localparam int unsigned AGE_W  = $clog2(AGE_LIMIT + 1);
    localparam int unsigned DPTR_W = (NDEM > 1) ? $clog2(NDEM) : 1;
    localparam int unsigned PPTR_W = (NPF > 1) ? $clog2(NPF) : 1;

    logic [NQ-1:0]     q_hit;
    logic [CNT_W-1:0]  tbl_cnt;
    logic [CNT_W-1:0]  pf_count_w;
    logic              tbl_full;
    logic              pf_full;
    logic [NDEM-1:0]   dem_elig;
    logic [NPF-1:0]    pf_elig;
    logic              dem_found;
    logic              pf_found;
    logic [DPTR_W-1:0] dem_idx;
    logic [PPTR_W-1:0] pf_idx;
    logic              dem_win;
    logic              pf_win;
    logic              win_hit;
    logic              acc_valid;
    logic              issue;
    logic [ADDR_W-1:0] acc_addr;
    logic [DPTR_W-1:0] dem_ptr_q, dem_ptr_d;
    logic [PPTR_W-1:0] pf_ptr_q, pf_ptr_d;
    logic [AGE_W-1:0]  age_q, age_d;
    int                di;
    int                pi;

    mem_inflight_table #(
        .NQ      (NQ),
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .q_addr      ({pf_addr, dem_addr}),
        .q_hit       (q_hit),
        .acc_valid   (acc_valid),
        .acc_pf      (pf_win),
        .acc_addr    (acc_addr),
        .rsp_valid   (mem_ready),
        .rsp_addr    (mem_addr_out),
        .outstanding (tbl_cnt),
        .pf_count    (pf_count_w)
    );

    assign tbl_full = (tbl_cnt == CNT_W'(MAX_OUT));
    assign pf_full  = (pf_count_w >= CNT_W'(PF_MAX));

    // Eligibility, round-robin picks and class priority
    always_comb begin
        dem_elig  = '0;
        pf_elig   = '0;
        dem_found = 1'b0;
        pf_found  = 1'b0;
        dem_idx   = '0;
        pf_idx    = '0;
        di        = 0;
        pi        = 0;
        dem_win   = 1'b0;
        pf_win    = 1'b0;
        win_hit   = 1'b0;
        acc_addr  = '0;
        dem_grant = '0;
        pf_grant  = '0;
        for (int i = 0; i < NDEM; i++) begin
            dem_elig[i] = dem_valid[i] && (q_hit[i] || !tbl_full);
        end
        for (int j = 0; j < NPF; j++) begin
            pf_elig[j] = pf_valid[j] && (q_hit[NDEM+j] || (!tbl_full && !pf_full));
        end
        for (int k = 0; k < NDEM; k++) begin
            di = (int'(dem_ptr_q) + k) % int'(NDEM);
            if (!dem_found && dem_elig[di]) begin
                dem_found = 1'b1;
                dem_idx   = DPTR_W'(di);
            end
        end
        for (int k = 0; k < NPF; k++) begin
            pi = (int'(pf_ptr_q) + k) % int'(NPF);
            if (!pf_found && pf_elig[pi]) begin
                pf_found = 1'b1;
                pf_idx   = PPTR_W'(pi);
            end
        end
        if (age_q == AGE_W'(AGE_LIMIT) && (|pf_valid) && pf_found) begin
            pf_win = 1'b1;
        end else if (dem_found) begin
            dem_win = 1'b1;
        end else if (pf_found) begin
            pf_win = 1'b1;
        end
        if (dem_win) begin
            acc_addr = dem_addr[int'(dem_idx)*ADDR_W +: ADDR_W];
            win_hit  = q_hit[dem_idx];
            if (rst_n) dem_grant[dem_idx] = 1'b1;
        end else if (pf_win) begin
            acc_addr = pf_addr[int'(pf_idx)*ADDR_W +: ADDR_W];
            win_hit  = q_hit[NDEM + int'(pf_idx)];
            if (rst_n) pf_grant[pf_idx] = 1'b1;
        end
    end

    assign acc_valid = (dem_win || pf_win) && rst_n;
    assign issue     = acc_valid && !win_hit;

    // Pointer advance and prefetch age tracking
    always_comb begin
        dem_ptr_d = dem_ptr_q;
        pf_ptr_d  = pf_ptr_q;
        age_d     = age_q;
        if (dem_win) begin
            dem_ptr_d = DPTR_W'((int'(dem_idx) + 1) % int'(NDEM));
        end
        if (pf_win) begin
            pf_ptr_d = PPTR_W'((int'(pf_idx) + 1) % int'(NPF));
        end
        if (pf_win || !(|pf_valid)) begin
            age_d = '0;
        end else if (age_q < AGE_W'(AGE_LIMIT)) begin
            age_d = age_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dem_ptr_q <= '0;
            pf_ptr_q  <= '0;
            age_q     <= '0;
            mem_re    <= 1'b0;
            mem_raddr <= '0;
        end else begin
            dem_ptr_q <= dem_ptr_d;
            pf_ptr_q  <= pf_ptr_d;
            age_q     <= age_d;
            mem_re    <= issue;
            if (issue) begin
                mem_raddr <= acc_addr;
            end
        end
    end

    assign outstanding = 4'(tbl_cnt);
    assign busy        = rst_n && ((tbl_cnt != '0) || (|dem_valid) || (|pf_valid));

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with hand-computed expectations.
module tb_mem_port_arb;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dem_valid;
    logic [31:0] dem_addr;
    logic [1:0]  dem_grant;
    logic [1:0]  pf_valid;
    logic [31:0] pf_addr;
    logic [1:0]  pf_grant;
    logic        mem_re;
    logic [15:0] mem_raddr;
    logic        mem_ready;
    logic [15:0] mem_addr_out;
    logic [3:0]  outstanding;
    logic        busy;

    int n_tests;
    int n_fail;
    int cyc;

    mem_port_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dem_valid    (dem_valid),
        .dem_addr     (dem_addr),
        .dem_grant    (dem_grant),
        .pf_valid     (pf_valid),
        .pf_addr      (pf_addr),
        .pf_grant     (pf_grant),
        .mem_re       (mem_re),
        .mem_raddr    (mem_raddr),
        .mem_ready    (mem_ready),
        .mem_addr_out (mem_addr_out),
        .outstanding  (outstanding),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [15:0] a);
        mem_ready    = 1'b1;
        mem_addr_out = a;
        step();
        mem_ready    = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        dem_valid = '0; dem_addr = '0;
        pf_valid = '0; pf_addr = '0;
        mem_ready = 1'b0; mem_addr_out = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_mem_re", 32'(mem_re), 0);
        check("rst_raddr", 32'(mem_raddr), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();

        // Stray response with an empty table
        respond(16'h1234);
        check("stray_rsp", 32'(outstanding), 0);

        // Single demand issue and free
        dem_valid = 2'b01; dem_addr[15:0] = 16'h0040;
        #1;
        check("t1_grant", 32'(dem_grant), 32'h1);
        check("t1_busy", 32'(busy), 1);
        step();
        dem_valid = '0;
        check("t1_mem_re", 32'(mem_re), 1);
        check("t1_raddr", 32'(mem_raddr), 32'h0040);
        check("t1_out", 32'(outstanding), 1);
        step();
        check("t1_re_pulse", 32'(mem_re), 0);
        respond(16'h0040);
        check("t1_freed", 32'(outstanding), 0);

        // Prefetch issue, then demand merge with promotion
        pf_valid = 2'b01; pf_addr[15:0] = 16'h0100;
        #1;
        check("t2_pf_grant", 32'(pf_grant), 32'h1);
        step();
        pf_valid = '0;
        check("t2_raddr", 32'(mem_raddr), 32'h0100);
        check("t2_pfcnt", 32'(dut.pf_count_w), 1);
        dem_valid = 2'b01; dem_addr[15:0] = 16'h0100;
        #1;
        check("t2_merge_grant", 32'(dem_grant), 32'h1);
        step();
        dem_valid = '0;
        check("t2_no_reissue", 32'(mem_re), 0);
        check("t2_out", 32'(outstanding), 1);
        check("t2_promoted", 32'(dut.pf_count_w), 0);
        respond(16'h0100);

        // Two demands: dem_ptr is 1 after the earlier grants to index 0
        dem_valid = 2'b11; dem_addr = {16'h0020, 16'h0010};
        #1;
        check("t3_grant_a", 32'(dem_grant), 32'h2);
        step();
        dem_valid = 2'b01;
        check("t3_raddr_a", 32'(mem_raddr), 32'h0020);
        #1;
        check("t3_grant_b", 32'(dem_grant), 32'h1);
        step();
        dem_valid = '0;
        check("t3_re_b", 32'(mem_re), 1);
        check("t3_raddr_b", 32'(mem_raddr), 32'h0010);
        check("t3_out", 32'(outstanding), 2);
        respond(16'h0010);
        respond(16'h0020);
        check("t3_freed", 32'(outstanding), 0);

        // Prefetch throttle at four in flight
        for (int i = 0; i < 4; i++) begin
            pf_valid = 2'b01; pf_addr[15:0] = 16'h0200 + 16'(i);
            #1;
            check("t4_pf_fill", 32'(pf_grant), 32'h1);
            step();
        end
        pf_addr[15:0] = 16'h0300;
        check("t4_out4", 32'(outstanding), 4);
        #1;
        check("t4_blocked", 32'(pf_grant), 0);
        step();
        check("t4_blocked2", 32'(pf_grant), 0);
        check("t4_no_re", 32'(mem_re), 0);
        mem_ready = 1'b1; mem_addr_out = 16'h0200;
        #1;
        check("t4_blocked_rsp", 32'(pf_grant), 0);
        step();
        mem_ready = 1'b0;
        #1;
        check("t4_granted", 32'(pf_grant), 32'h1);
        step();
        pf_valid = '0;
        check("t4_raddr", 32'(mem_raddr), 32'h0300);
        check("t4_out", 32'(outstanding), 4);
        respond(16'h0201);
        respond(16'h0202);
        respond(16'h0203);
        respond(16'h0300);
        check("t4_freed", 32'(outstanding), 0);

        // Age escape under continuous merging demand
        dem_valid = 2'b01; dem_addr[15:0] = 16'h0500;
        step();
        dem_valid = 2'b11; dem_addr = {16'h0500, 16'h0500};
        pf_valid = 2'b10; pf_addr[31:16] = 16'h0600;
        cyc = -1;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (pf_grant == 2'b10) begin
                cyc = c;
                check("t5_dem_held_off", 32'(dem_grant), 0);
                break;
            end
            @(posedge clk);
        end
        check("t5_age_cycle", 32'(cyc), 32'd16);
        step();
        pf_valid = '0; dem_valid = '0;
        check("t5_raddr", 32'(mem_raddr), 32'h0600);
        respond(16'h0500);
        respond(16'h0600);
        check("t5_freed", 32'(outstanding), 0);

        // Fill the table, check full blocking, then reset mid-flight
        for (int i = 0; i < 8; i++) begin
            dem_valid = 2'b01; dem_addr[15:0] = 16'h0700 + 16'(i);
            #1;
            check("t6_fill", 32'(dem_grant), 32'h1);
            step();
        end
        dem_addr[15:0] = 16'h0708;
        check("t6_full", 32'(outstanding), 8);
        #1;
        check("t6_full_block", 32'(dem_grant), 0);
        dem_valid = 2'b11; dem_addr[31:16] = 16'h0703;
        #1;
        check("t6_full_merge", 32'(dem_grant), 32'h2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_out", 32'(outstanding), 0);
        check("t6_rst_re", 32'(mem_re), 0);
        check("t6_rst_raddr", 32'(mem_raddr), 0);
        check("t6_rst_grant", 32'(dem_grant), 0);
        check("t6_rst_busy", 32'(busy), 0);
        dem_valid = '0;
        step();
        rst_n = 1'b1;
        step();
        respond(16'h0700);
        check("t6_late_rsp", 32'(outstanding), 0);
        check("t6_late_re", 32'(mem_re), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
Name: mem_port_arb

Overview:
- Shares the single long-latency data memory read port between demand requesters (load units) and prefetch requesters (prefetchers).
- Tracks every in-flight read so that duplicate addresses are merged rather than re-issued.
- Demand has priority over prefetch, which is age-protected against starvation; outstanding prefetches are throttled.
- Sits between the load/prefetch logic and the memory read port; memory responses go straight from memory to the requesters, and this block only snoops them.

Parameters:
- NDEM, 2, number of demand requesters
- NPF, 2, number of prefetch requesters
- MAX_OUT, 8, in-flight table entries (max outstanding reads)
- PF_MAX, 4, max in-flight entries marked prefetch
- AGE_LIMIT, 16, cycles a waiting prefetch may be passed over before forced priority

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- dem_valid  in  NDEM  demand request; held with its address until granted
- dem_addr  in  16*NDEM  demand addresses, requester i at [16i+15:16i]
- dem_grant  out  NDEM  one-hot-or-zero; request accepted this cycle (issued or merged)
- pf_valid  in  NPF  prefetch request; held until granted
- pf_addr  in  16*NPF  prefetch addresses
- pf_grant  out  NPF  one-hot-or-zero acceptance
- mem_re  out  1  read request pulse to memory
- mem_raddr  out  16  read address, valid when mem_re=1
- mem_ready  in  1  memory response broadcast valid
- mem_addr_out  in  16  address of the response
- outstanding  out  4  count of valid table entries
- busy  out  1  any valid table entry or any requester valid

Behaviour:
- Reset (async, rst_n=0):
  - All table entries invalid; pf_count=0; round-robin pointers=0; age counter=0.
  - mem_re=0, mem_raddr=0, grants=0, outstanding=0.
  - Responses arriving after reset that match no entry are ignored.
- Table entry: valid, is_pf, addr[15:0]. At most one valid entry per address.
- Grants are combinational from registered state and current inputs.
- At most one requester is granted per cycle across both classes.
- Selection order each cycle:
  1. Forced prefetch, if age counter = AGE_LIMIT and any pf_valid.
  2. Demand, round-robin from dem_ptr.
  3. Prefetch, round-robin from pf_ptr.
  - The pointer advances past the granted index.
- Granted address matches a valid entry (merge):
  - Grant asserted, no memory issue.
  - If the winner is demand and the entry is_pf: clear is_pf, decrement pf_count (promotion).
- Granted address misses the table (issue):
  - Allocate the lowest-index free entry and set is_pf for prefetch.
  - On the next clock edge, mem_re=1 and mem_raddr=addr for exactly one cycle.
  - Issue latency: grant in cycle N, mem_re in cycle N+1.
- Blocking rules:
  - Table full (outstanding=MAX_OUT): no issue-grants; merge-grants still allowed.
  - pf_count=PF_MAX: prefetch issue-grants blocked; prefetch merges are allowed and are a no-op.
  - A blocked candidate is skipped and the next eligible candidate in order is granted.
- Responses: when mem_ready and mem_addr_out matches a valid entry, that entry is freed at the edge (decrementing pf_count if is_pf). Non-matching responses are ignored.
- Simultaneous free and allocate in one cycle are both applied. Full/PF_MAX checks use pre-edge state (no bypass), so a slot freed this cycle is usable next cycle.
- Same address from two requesters in one cycle: the winner issues; the loser stays pending and merges on a later cycle.
- Age counter:
  - Increments each cycle any pf_valid is high and no prefetch is granted.
  - Resets to 0 on any pf_grant or when no pf_valid.
  - Saturates at AGE_LIMIT.
- outstanding is the registered popcount of valid entries.

Decomposition:
- Package mem_arb_pkg: ADDR_W=16, inflight_entry_t {valid, is_pf, addr}, default parameter constants.
- Sub-module mem_inflight_table: CAM lookup, allocate/free/promote, outstanding and pf_count.
- Top level holds arbitration, pointers, age counter and the issue register.

Test Plan:
- Single demand dem_valid[0], addr 0x0040 -> dem_grant[0] same cycle; mem_re=1, mem_raddr=0x0040 next cycle; outstanding=1; mem_ready with 0x0040 -> outstanding=0.
- Prefetch 0x0100 issued, then demand 0x0100 -> demand merge-grant, no second mem_re, entry promoted (pf_count 1->0).
- dem_valid=2'b11 with 0x10 and 0x20 held -> grants alternate 0,1; two mem_re pulses in consecutive-grant order.
- PF_MAX=4 prefetches in flight, fifth pf 0x0300 -> no pf_grant until one prefetch response, then granted the cycle after.
- Continuous demand with pf_valid[1] held -> pf_grant[1] within AGE_LIMIT+1 cycles.
- Fill table to 8, assert rst_n=0 mid-flight -> all outputs 0 immediately; late responses after reset leave outstanding=0.
